rs232_rx_nbytes: RTL

RS232_RX_NBYTES -- requirements
Module: rs232_rx_nbytes

---
 rtl/rs232_pkg.sv | 16 +
 rtl/rs232_rx_nbytes_if.sv | 21 ++
 rtl/rs232_baud_tick.sv | 26 ++
 rtl/rs232_rx_nbytes.sv | 137 +++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 receiver and transmitter: default bit period
// and the receiver state encoding.
package rs232_pkg;

  // 50 MHz / 4800 baud
  localparam logic [15:0] BAUD_RATE_DEF = 16'h28B0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } rs232_state_e;

endpackage

// File: rtl/rs232_rx_nbytes_if.sv
// Serial line in, assembled frame and status flags out.
interface rs232_rx_nbytes_if #(
  parameter int W = 64
);
  logic         Rs232_Rxd;
  logic [W-1:0] data_out;
  logic         rx_start_flag;
  logic         rx_done_flag;
  logic         rx_err_flag;
  logic         rx_busy;

  modport master (
    output Rs232_Rxd,
    input  data_out, rx_start_flag, rx_done_flag, rx_err_flag, rx_busy
  );

  modport slave (
    input  Rs232_Rxd,
    output data_out, rx_start_flag, rx_done_flag, rx_err_flag, rx_busy
  );
endinterface

// File: rtl/rs232_baud_tick.sv
// Bit-period counter; flags the half-bit and full-bit points of the current period.
module rs232_baud_tick
  import rs232_pkg::*;
#(
  parameter logic [15:0] BAUD_RATE = BAUD_RATE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic mid_tick,
  output logic full_tick
);
  localparam logic [15:0] HALF_LAST = BAUD_RATE / 16'd2 - 16'd1;
  localparam logic [15:0] FULL_LAST = BAUD_RATE - 16'd1;

  logic [15:0] cnt;

  assign mid_tick  = (cnt == HALF_LAST);
  assign full_tick = (cnt == FULL_LAST);

  // wrap on full_tick keeps the count at or below BAUD_RATE-1
  always_ff @(posedge clk) begin
    if (reset || clr || full_tick) cnt <= '0;
    else                           cnt <= cnt + 16'd1;
  end
endmodule

// File: rtl/rs232_rx_nbytes.sv
// RS-232 receiver that assembles n bytes of N bits each into one wide word,
// first byte in the most significant slice.
module rs232_rx_nbytes
  import rs232_pkg::*;
#(
  parameter int          n         = 8,
  parameter int          N         = 8,
  parameter int          mlb       = 0,
  parameter logic [15:0] BAUD_RATE = BAUD_RATE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  rs232_rx_nbytes_if.slave   bus
);
  localparam int IW = (n > 1) ? $clog2(n) : 1;
  localparam int CW = $clog2(n + 1);
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_TOP   = IW'(n - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(n - 1);
  localparam logic [BW-1:0] BIT_FIRST = (mlb != 0) ? BW'(0) : BW'(N - 1);
  localparam logic [BW-1:0] BIT_LAST  = (mlb != 0) ? BW'(N - 1) : BW'(0);

  rs232_state_e state, state_nx;

  logic          rxd_m, rxd_s, rxd_d;
  logic [2:0]    vld_pipe;
  logic [BW-1:0] bit_idx;
  logic [N-1:0]  sh;
  logic [IW-1:0] byte_idx;
  logic [CW-1:0] byte_cnt;
  logic [N*n-1:0] data_q;
  logic          start_q, done_q, err_q;

  logic mid_tick, full_tick, clr;
  logic fall, last_byte;
  logic start_ok, sample_bit, byte_ok, frame_err;

  // vld_pipe fills after reset so the reset-forced 1s in the synchronizer
  // cannot masquerade as a falling edge when the line is low at release
  assign fall      = vld_pipe[2] && rxd_d && !rxd_s;
  assign last_byte = (byte_cnt == CNT_LAST);

  rs232_baud_tick #(.BAUD_RATE(BAUD_RATE)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .mid_tick  (mid_tick),
    .full_tick (full_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start_ok   = 1'b0;
    sample_bit = 1'b0;
    byte_ok    = 1'b0;
    frame_err  = 1'b0;
    case (state)
      IDLE:  if (fall) state_nx = START;
      START: if (mid_tick) begin
        if (!rxd_s) begin
          start_ok = 1'b1;
          state_nx = DATA;
        end else begin
          state_nx = IDLE;
        end
      end
      DATA:  if (full_tick) begin
        sample_bit = 1'b1;
        if (bit_idx == BIT_LAST) state_nx = STOP;
      end
      STOP:  if (full_tick) begin
        if (rxd_s) begin
          byte_ok  = 1'b1;
          state_nx = last_byte ? DONE : IDLE;
        end else begin
          frame_err = 1'b1;
          state_nx  = IDLE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    clr = (state_nx != state) || (state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_m    <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_d    <= 1'b1;
      vld_pipe <= '0;
      bit_idx  <= BIT_FIRST;
      sh       <= '0;
      byte_idx <= IDX_TOP;
      byte_cnt <= '0;
      data_q   <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rxd_m    <= bus.Rs232_Rxd;
      rxd_s    <= rxd_m;
      rxd_d    <= rxd_s;
      vld_pipe <= {vld_pipe[1:0], 1'b1};
      start_q  <= start_ok;
      done_q   <= byte_ok && last_byte;
      err_q    <= frame_err;

      if (start_ok) bit_idx <= BIT_FIRST;
      if (sample_bit) begin
        sh[bit_idx] <= rxd_s;
        bit_idx     <= (mlb != 0) ? bit_idx + 1'b1 : bit_idx - 1'b1;
      end

      if (byte_ok) begin
        data_q[int'(byte_idx) * N +: N] <= sh;
        byte_idx <= (byte_idx == '0) ? IDX_TOP : byte_idx - 1'b1;
        byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
      end else if (frame_err) begin
        byte_idx <= IDX_TOP;
        byte_cnt <= '0;
      end
    end
  end

  assign bus.data_out      = data_q;
  assign bus.rx_start_flag = start_q;
  assign bus.rx_done_flag  = done_q;
  assign bus.rx_err_flag   = err_q;
  assign bus.rx_busy       = (state != IDLE) || (byte_cnt != '0);

endmodule
